// File: rtl/hist_equalize_map_pkg.sv
// hist_equalize_map_pkg: build FSM states, pipeline constants and the elaboration-time scale helpers
package hist_equalize_map_pkg;
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
    localparam int DRAIN_CYC = 3;
    function automatic logic [63:0] calc_total(input logic [31:0] iw, input logic [31:0] ih);
        return 64'(iw) * 64'(ih);
    endfunction
    function automatic logic [63:0] calc_scale(input logic [31:0] dw, input logic [31:0] shift, input logic [63:0] total);
        return (((64'd1 << dw) - 64'd1) << shift) / total;
    endfunction
endpackage

// File: rtl/hist_equalize_map_eq_lut_ram.sv
// eq_lut_ram: ping-pong LUT storage, both banks in one array selected by the address MSB; registered read
module eq_lut_ram #(
    parameter int DW = 14
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [DW:0]   i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [DW:0]   i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [2**(DW+1)];
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/hist_equalize_map.sv
// hist_equalize_map: walks the histogram into a CDF-based equalization LUT in the inactive bank,
// swaps banks at frame start and remaps the live pixel stream through the active bank.
module hist_equalize_map
    import hist_equalize_map_pkg::*;
#(
    parameter int DW    = 14,
    parameter int IH    = 512,
    parameter int IW    = 640,
    parameter int TW    = 32,
    parameter int SHIFT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hist_start,
    output logic [DW-1:0] hist_cnt_addr,
    input  logic [TW-1:0] hist_cnt_out,
    input  logic          vsync,
    input  logic          din_valid,
    input  logic [DW-1:0] din,
    output logic          dout_valid,
    output logic [DW-1:0] dout,
    output logic          build_busy,
    output logic          build_done,
    output logic          lut_valid
);
    localparam int PW = TW + SHIFT;
    localparam logic [PW-1:0] SCALE = PW'(calc_scale(DW, SHIFT, calc_total(IW, IH)));
    localparam logic [PW-1:0] MAXV  = PW'({DW{1'b1}});
    state_t        r_state;
    logic [DW-1:0] r_addr, r_k1, r_k2, r_k3, r_din1, r_dout;
    logic [1:0]    r_cnt;
    logic          r_v1, r_v2, r_v3;
    logic [TW-1:0] r_cdf;
    logic [PW-1:0] r_prod;
    logic          r_busy, r_done, r_pending, r_bank, r_lut_valid, r_vs_d;
    logic          r_pv1, r_lv1, r_dv;
    logic [PW-1:0] w_shift;
    logic [DW-1:0] w_map, w_rd;
    logic          w_swap;
    always_comb begin
        w_shift = r_prod >> SHIFT;
        w_map   = (w_shift > MAXV) ? {DW{1'b1}} : w_shift[DW-1:0];
        w_swap  = vsync & ~r_vs_d & r_pending & (r_state == IDLE);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (hist_start) begin
                    r_state <= READ;
                    r_busy  <= 1'b1;
                    r_addr  <= '0;
                end
                READ: if (r_addr == {DW{1'b1}}) begin
                    r_state <= DRAIN;
                    r_cnt   <= '0;
                end else r_addr <= r_addr + DW'(1);
                DRAIN: if (r_cnt == 2'(DRAIN_CYC - 1)) begin
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end else r_cnt <= r_cnt + 2'd1;
                DONE: begin
                    r_state   <= IDLE;
                    r_pending <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
            if (w_swap) r_pending <= 1'b0;
        end
    end
    // Address k travels alongside its data: count arrives k+1, CDF k+2, product k+3 (written to LUT).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
            r_v3  <= 1'b0;
            r_cdf <= '0;
        end else begin
            r_v1 <= (r_state == READ);
            r_v2 <= r_v1;
            r_v3 <= r_v2;
            if (r_state == IDLE && hist_start) r_cdf <= '0;
            else if (r_v1) r_cdf <= r_cdf + hist_cnt_out;
        end
        r_k1   <= r_addr;
        r_k2   <= r_k1;
        r_k3   <= r_k2;
        r_prod <= {{SHIFT{1'b0}}, r_cdf} * SCALE;
    end
    eq_lut_ram #(.DW(DW)) u_ram (
        .clk     (clk),
        .i_we    (r_v3),
        .i_waddr ({~r_bank, r_k3}),
        .i_wdata (w_map),
        .i_raddr ({r_bank, din}),
        .o_rdata (w_rd)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bank      <= 1'b0;
            r_lut_valid <= 1'b0;
            r_vs_d      <= 1'b0;
            r_pv1       <= 1'b0;
            r_lv1       <= 1'b0;
            r_dv        <= 1'b0;
            r_dout      <= '0;
        end else begin
            r_vs_d <= vsync;
            if (w_swap) begin
                r_bank      <= ~r_bank;
                r_lut_valid <= 1'b1;
            end
            r_pv1 <= din_valid;
            r_lv1 <= r_lut_valid;
            r_dv  <= r_pv1;
            if (r_pv1) r_dout <= r_lv1 ? w_rd : r_din1;
        end
        r_din1 <= din;
    end
    assign hist_cnt_addr = r_addr;
    assign dout_valid    = r_dv;
    assign dout          = r_dout;
    assign build_busy    = r_busy;
    assign build_done    = r_done;
    assign lut_valid     = r_lut_valid;
endmodule

// File: tb/tb_hist_equalize_map.sv
// tb_hist_equalize_map: directed LUT builds on a 4x4 image with 4-bit pixels; a queue-based
// scoreboard checks every remapped pixel while the main thread checks control timing.
module tb_hist_equalize_map;
    localparam int DW = 4;
    logic          clk = 1'b0, rst = 1'b1, hist_start = 1'b0, vsync = 1'b0, din_valid = 1'b0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] hist_cnt_addr, dout;
    logic [31:0]   hist_cnt_out;
    logic          dout_valid, build_busy, build_done, lut_valid;
    logic [31:0]   hist [16];
    logic [DW-1:0] exp_q [$];
    int            n_chk = 0, n_pass = 0;
    int            cyc, n_done, first;
    always #5 clk = ~clk;
    always @(posedge clk) hist_cnt_out <= hist[hist_cnt_addr];
    hist_equalize_map #(.DW(DW), .IH(4), .IW(4), .TW(32), .SHIFT(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .hist_start    (hist_start),
        .hist_cnt_addr (hist_cnt_addr),
        .hist_cnt_out  (hist_cnt_out),
        .vsync         (vsync),
        .din_valid     (din_valid),
        .din           (din),
        .dout_valid    (dout_valid),
        .dout          (dout),
        .build_busy    (build_busy),
        .build_done    (build_done),
        .lut_valid     (lut_valid)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, want);
    endtask
    always @(negedge clk) begin
        if (dout_valid) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL dout_unexpected: got %0d expected no output", dout);
            end else chk("dout", 32'(dout), 32'(exp_q.pop_front()));
        end
    end
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic send(input logic [DW-1:0] px, input logic [DW-1:0] want);
        @(negedge clk);
        din_valid = 1'b1;
        din = px;
        exp_q.push_back(want);
    endtask
    task automatic idle(input int n);
        @(negedge clk);
        din_valid = 1'b0;
        tick(n - 1);
    endtask
    task automatic vs_pulse();
        @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
    endtask
    task automatic start_build();
        @(negedge clk);
        hist_start = 1'b1;
        @(negedge clk);
        hist_start = 1'b0;
    endtask
    task automatic build(output int c);
        start_build();
        c = 1;
        while (!build_done && c < 100) begin
            @(negedge clk);
            c++;
        end
    endtask
    task automatic wait_done();
        for (int i = 0; i < 100 && !build_done; i++) @(negedge clk);
    endtask
    task automatic set_hist(input int a, input logic [31:0] va, input int b, input logic [31:0] vb, input logic [31:0] rest);
        for (int i = 0; i < 16; i++) hist[i] = rest;
        hist[a] = va;
        hist[b] = vb;
    endtask
    task automatic chk_reset(input string tag);
        chk({tag, "_addr"}, 32'(hist_cnt_addr), 32'd0);
        chk({tag, "_dout_valid"}, 32'(dout_valid), 32'd0);
        chk({tag, "_dout"}, 32'(dout), 32'd0);
        chk({tag, "_busy"}, 32'(build_busy), 32'd0);
        chk({tag, "_done"}, 32'(build_done), 32'd0);
        chk({tag, "_lut_valid"}, 32'(lut_valid), 32'd0);
    endtask
    initial begin
        set_hist(0, 0, 0, 0, 0);
        tick(3);
        chk_reset("reset");
        rst = 1'b0;
        // Identity pass-through before any LUT exists
        for (int i = 0; i < 16; i++) send(4'(i), 4'(i));
        chk("lut_valid_identity", 32'(lut_valid), 32'd0);
        idle(4);
        // Single-bin histogram: everything below bin 5 maps to 0, the rest saturates
        set_hist(5, 16, 5, 16, 0);
        @(negedge clk);
        hist_start = 1'b1;
        @(negedge clk);
        hist_start = 1'b0;
        chk("busy_rise", 32'(build_busy), 32'd1);
        cyc = 1;
        while (!build_done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("build_len", 32'(cyc), 32'd20);
        chk("busy_at_done", 32'(build_busy), 32'd0);
        tick(1);
        chk("done_single", 32'(build_done), 32'd0);
        chk("lut_valid_pre_swap", 32'(lut_valid), 32'd0);
        vs_pulse();
        chk("lut_valid_swap", 32'(lut_valid), 32'd1);
        send(3, 0); send(5, 15); send(12, 15); send(4, 0);
        idle(4);
        // Uniform histogram
        set_hist(0, 1, 0, 1, 1);
        build(cyc);
        chk("build_len_uniform", 32'(cyc), 32'd20);
        tick(1);
        vs_pulse();
        send(0, 0); send(7, 7); send(15, 15); send(3, 3); send(10, 10);
        idle(4);
        // vsync during a build must not swap; the swap waits for the next rise
        set_hist(5, 16, 5, 16, 0);
        start_build();
        tick(4);
        vs_pulse();
        chk("lut_valid_defer", 32'(lut_valid), 32'd1);
        send(3, 3); send(12, 12);
        idle(1);
        wait_done();
        chk("defer_done_seen", 32'(build_done), 32'd1);
        tick(1);
        send(3, 3); send(12, 12);
        idle(4);
        vs_pulse();
        send(3, 0); send(12, 15);
        idle(4);
        // hist_start re-pulsed during READ is ignored
        set_hist(0, 8, 15, 8, 0);
        start_build();
        cyc = 1;
        n_done = 0;
        first = 0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            hist_start = (cyc == 5);
            if (build_done) begin
                n_done++;
                if (first == 0) first = cyc;
            end
        end
        hist_start = 1'b0;
        chk("restart_done_count", 32'(n_done), 32'd1);
        chk("restart_build_len", 32'(first), 32'd20);
        vs_pulse();
        send(0, 7); send(9, 7); send(15, 15);
        idle(4);
        // Reset mid-build abandons the build and masks the LUT
        set_hist(5, 16, 5, 16, 0);
        start_build();
        tick(5);
        rst = 1'b1;
        tick(2);
        chk_reset("midreset");
        rst = 1'b0;
        tick(25);
        vs_pulse();
        chk("lut_valid_after_reset", 32'(lut_valid), 32'd0);
        send(3, 3); send(9, 9);
        idle(4);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
